// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Define BCD_AUTO_EN to self-trigger whenever bin differs from the last converted value.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = 4 * DIGITS + WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      bin_sh;
  logic [4*DIGITS-1:0]   digits;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         step;
  logic                  go;

  // One double-dabble iteration: correct digits >= 5, then shift {digits, binary} left.
  function automatic logic [TW-1:0] dabble_step(input logic [4*DIGITS-1:0] d,
                                                input logic [WIDTH-1:0]    b);
    logic [4*DIGITS-1:0] adj;
    adj = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = d[4*i +: 4];
      end
    end
    return {adj, b} << 1;
  endfunction

  assign step = dabble_step(digits, bin_sh);

`ifdef BCD_AUTO_EN
  logic [WIDTH-1:0] last_bin;
  assign go = (bin != last_bin);
`else
  assign go = start;
`endif

  // Conversion FSM with registered busy/done/bcd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bin_sh   <= {WIDTH{1'b0}};
      digits   <= {(4*DIGITS){1'b0}};
      cnt      <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= {(4*DIGITS){1'b0}};
`ifdef BCD_AUTO_EN
      last_bin <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (go) begin
            bin_sh   <= bin;
            digits   <= {(4*DIGITS){1'b0}};
            cnt      <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= S_SHIFT;
`ifdef BCD_AUTO_EN
            last_bin <= bin;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          {digits, bin_sh} <= step;
          cnt              <= cnt - CW'(1);
          // Final shift: publish the result as we enter DONE so bcd never shows partials.
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= step[TW-1:WIDTH];
            state <= S_DONE;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default build): directed cases, full sweep, random values.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion; optionally pulses start with pv during SHIFT cycle pulse_at (0 = none).
  task automatic run(input logic [7:0] v, input int pulse_at, input logic [7:0] pv);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      if (i == pulse_at) begin
        bin   = pv;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("bcd_value", 32'(bcd), 32'(ref_bcd(int'(v))));
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("bcd_hold", 32'(bcd), 32'(ref_bcd(int'(v))));
  endtask

  initial begin
    logic [7:0] rv;
    int         seen;
    reset = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(8'd255, 0, 8'd0);
    run(8'd0,   0, 8'd0);
    run(8'd99,  0, 8'd0);
    run(8'd100, 0, 8'd0);

    // A start during SHIFT is ignored; the pulse must not cause a second conversion.
    run(8'd42, 3, 8'd7);
    repeat (12) begin
      @(negedge clk);
      check("no_queued_done", 32'(done), 32'd0);
      check("bcd_still_42", 32'(bcd), 32'h042);
    end
    run(8'd7, 0, 8'd0);

    // Reset at the 4th SHIFT cycle aborts the conversion.
    @(negedge clk);
    bin   = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run(8'd13, 0, 8'd0);

    for (int v = 0; v < 256; v++) begin
      run(8'(v), 0, 8'd0);
    end

    repeat (20) begin
      rv = 8'($urandom_range(255, 0));
      run(rv, int'($urandom_range(8, 0)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
